// File: rtl/msi_irq_vec.sv
// msi_irq_vec: collects up to 32 core interrupts and serialises them as
// single MSI requests with round-robin arbitration, per-source masking,
// vector folding to the host-allocated vector count, fail/timeout retry,
// and readable pending/overrun status.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | nothing in flight; waits for any pending & unmasked source
// ST_SELECT | round-robin pick from the pointer upward, latch CurIrq
// ST_SEND   | one-clock request pulse with the folded vector number
// ST_WAIT   | wait for grant/fail or the grant timeout
// ST_END    | advance the round-robin pointer past CurIrq

module msi_irq_vec #(
    parameter int          NumberOfInterrupts_Gen = 8,
    parameter logic [31:0] LevelInterrupt_Gen     = 32'h0,
    parameter int          GrantTimeout_Gen       = 1024
) (
    input  logic                              SysClk_ClkIn,
    input  logic                              SysRstN_RstIn,
    input  logic [NumberOfInterrupts_Gen-1:0] IrqIn_DatIn,
    input  logic [NumberOfInterrupts_Gen-1:0] IrqMask_DatIn,
    input  logic [NumberOfInterrupts_Gen-1:0] IrqClear_ValIn,
    input  logic                              MsiIrqEnable_EnIn,
    input  logic [2:0]                        MsiVectorWidth_DatIn,
    input  logic                              MsiGrant_ValIn,
    input  logic                              MsiFail_ValIn,
    output logic                              MsiReq_ValOut,
    output logic [4:0]                        MsiVectorNum_DatOut,
    output logic [NumberOfInterrupts_Gen-1:0] IrqPending_DatOut,
    output logic [NumberOfInterrupts_Gen-1:0] IrqOverrun_DatOut
);

    localparam int N = NumberOfInterrupts_Gen;
    localparam logic [N-1:0] LVL      = LevelInterrupt_Gen[N-1:0];
    localparam logic [4:0]   LAST_IDX = 5'(N - 1);
    localparam logic [15:0]  TMO_LAST = 16'(GrantTimeout_Gen - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_SEND   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_END    = 3'd4;

    logic [N-1:0] sync1_q, sync2_q, ff_q;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] ovr_q, ovr_d;
    logic [N-1:0] evt, edge_only_evt, grant_clr, elig;
    logic [31:0]  elig32;

    logic [2:0]   state_q;
    logic [4:0]   ptr_q, cur_q;
    logic [15:0]  cnt_q;
    logic         req_q;
    logic [4:0]   vec_q;

    logic         grant_hit;
    logic         sel_found;
    logic [4:0]   sel_idx;
    logic [5:0]   idx6;
    logic [2:0]   w_eff;
    logic [5:0]   max_vec;
    logic [4:0]   vec_calc;
    logic [4:0]   ptr_wrap;

    assign MsiReq_ValOut       = req_q;
    assign MsiVectorNum_DatOut = vec_q;
    assign IrqPending_DatOut   = pend_q;
    assign IrqOverrun_DatOut   = ovr_q;

    // Two-flop synchroniser plus delay flop; wiped while MSI is disabled so
    // that re-enabling sees a held-high input as a fresh edge.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ff_q    <= '0;
        end else if (!MsiIrqEnable_EnIn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ff_q    <= '0;
        end else begin
            sync1_q <= IrqIn_DatIn;
            sync2_q <= sync1_q;
            ff_q    <= sync2_q;
        end
    end

    // Event detection and pending/overrun next state; an arriving event
    // beats both a clear pulse and a grant-clear in the same cycle.
    always_comb begin
        grant_hit     = (state_q == ST_WAIT) && MsiGrant_ValIn;
        evt           = (sync2_q & ~ff_q) | (ff_q & LVL);
        edge_only_evt = sync2_q & ~ff_q & ~LVL;
        grant_clr     = '0;
        for (int i = 0; i < N; i++) begin
            grant_clr[i] = grant_hit && (cur_q == 5'(i));
        end
        pend_d = (pend_q & ~(IrqClear_ValIn | grant_clr)) | evt;
        ovr_d  = (ovr_q & ~IrqClear_ValIn) | (edge_only_evt & pend_q & ~grant_clr);
    end

    // Pending and sticky overrun status registers.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            pend_q <= '0;
            ovr_q  <= '0;
        end else if (!MsiIrqEnable_EnIn) begin
            pend_q <= '0;
            ovr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    // Round-robin search: first eligible source at or above the pointer,
    // wrapping from N-1 back to 0.
    always_comb begin
        elig      = pend_q & ~IrqMask_DatIn;
        elig32    = 32'(elig);
        sel_found = 1'b0;
        sel_idx   = 5'd0;
        idx6      = 6'd0;
        for (int k = 0; k < N; k++) begin
            idx6 = {1'b0, ptr_q} + 6'(k);
            if (idx6 >= 6'(N)) begin
                idx6 = idx6 - 6'(N);
            end
            if (!sel_found && elig32[idx6[4:0]]) begin
                sel_found = 1'b1;
                sel_idx   = idx6[4:0];
            end
        end
    end

    // Vector folding: clamp the width to 5 and saturate the source number
    // to the highest allocated vector; also the wrapped next pointer.
    always_comb begin
        w_eff    = (MsiVectorWidth_DatIn > 3'd5) ? 3'd5 : MsiVectorWidth_DatIn;
        max_vec  = (6'd1 << w_eff) - 6'd1;
        vec_calc = ({1'b0, cur_q} > max_vec) ? max_vec[4:0] : cur_q;
        ptr_wrap = (cur_q >= LAST_IDX) ? 5'd0 : cur_q + 5'd1;
    end

    // Request sequencer; disabling MSI aborts any request in flight.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            state_q <= ST_IDLE;
            ptr_q   <= 5'd0;
            cur_q   <= 5'd0;
            cnt_q   <= 16'd0;
            req_q   <= 1'b0;
            vec_q   <= 5'd0;
        end else if (!MsiIrqEnable_EnIn) begin
            state_q <= ST_IDLE;
            ptr_q   <= 5'd0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_q <= 1'b0;
                    if (|elig) begin
                        state_q <= ST_SELECT;
                    end else begin
                        ptr_q <= 5'd0;
                    end
                end
                ST_SELECT: begin
                    req_q <= 1'b0;
                    if (sel_found) begin
                        cur_q   <= sel_idx;
                        state_q <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    req_q   <= 1'b1;
                    vec_q   <= vec_calc;
                    cnt_q   <= 16'd0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    req_q <= 1'b0;
                    cnt_q <= cnt_q + 16'd1;
                    if (MsiGrant_ValIn || MsiFail_ValIn || (cnt_q == TMO_LAST)) begin
                        state_q <= ST_END;
                    end
                end
                ST_END: begin
                    req_q   <= 1'b0;
                    ptr_q   <= ptr_wrap;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msi_irq_vec.sv
// Directed bench for msi_irq_vec: N=8, source 0 level-sensitive,
// grant timeout of 16 clocks.
module tb_msi_irq_vec;

    localparam int N   = 8;
    localparam int TMO = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] irq_in, irq_mask, irq_clr;
    logic         en;
    logic [2:0]   vw;
    logic         grant, fail;
    logic         req;
    logic [4:0]   vec;
    logic [N-1:0] pend, ovr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         src;
        logic [2:0] width;
        logic [4:0] exp_vec;
    } vec_t;

    vec_t tbl[8];

    msi_irq_vec #(
        .NumberOfInterrupts_Gen(N),
        .LevelInterrupt_Gen    (32'h0000_0001),
        .GrantTimeout_Gen      (TMO)
    ) dut (
        .SysClk_ClkIn        (clk),
        .SysRstN_RstIn       (rst_n),
        .IrqIn_DatIn         (irq_in),
        .IrqMask_DatIn       (irq_mask),
        .IrqClear_ValIn      (irq_clr),
        .MsiIrqEnable_EnIn   (en),
        .MsiVectorWidth_DatIn(vw),
        .MsiGrant_ValIn      (grant),
        .MsiFail_ValIn       (fail),
        .MsiReq_ValOut       (req),
        .MsiVectorNum_DatOut (vec),
        .IrqPending_DatOut   (pend),
        .IrqOverrun_DatOut   (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Ticks until req is seen high; cyc returns the number of ticks taken.
    task automatic wait_req(input int maxc, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!req && cyc < maxc);
        if (!req) begin
            errors++;
            checks++;
            $display("FAIL req_wait_timeout actual=none expected=req within %0d", maxc);
        end
    endtask

    task automatic grant_now();
        grant = 1'b1;
        tick();
        grant = 1'b0;
    endtask

    int cyc;
    int req_seen;

    initial begin
        tbl[0] = '{src: 5, width: 3'd3, exp_vec: 5'd5};
        tbl[1] = '{src: 6, width: 3'd1, exp_vec: 5'd1};
        tbl[2] = '{src: 6, width: 3'd0, exp_vec: 5'd0};
        tbl[3] = '{src: 6, width: 3'd7, exp_vec: 5'd6};
        tbl[4] = '{src: 3, width: 3'd5, exp_vec: 5'd3};
        tbl[5] = '{src: 7, width: 3'd2, exp_vec: 5'd3};
        tbl[6] = '{src: 2, width: 3'd2, exp_vec: 5'd2};
        tbl[7] = '{src: 1, width: 3'd0, exp_vec: 5'd0};

        rst_n = 1'b0; irq_in = '0; irq_mask = '0; irq_clr = '0;
        en = 1'b1; vw = 3'd3; grant = 1'b0; fail = 1'b0;
        #23;
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_vec", {27'd0, vec}, 32'd0);
        check("rst_pend", {24'd0, pend}, 32'd0);
        check("rst_ovr", {24'd0, ovr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();

        // Source 5: pending two clocks after the first sampling edge,
        // request three clocks later, grant two clocks after the request.
        irq_in[5] = 1'b1;
        tick(); tick();
        check("s5_pend_early", {31'd0, pend[5]}, 32'd0);
        tick();
        check("s5_pend_rise", {31'd0, pend[5]}, 32'd1);
        wait_req(20, cyc);
        check("s5_req_lat", cyc, 3);
        check("s5_vec", {27'd0, vec}, 32'd5);
        tick();
        check("s5_req_pulse", {31'd0, req}, 32'd0);
        grant_now();
        check("s5_pend_clr", {31'd0, pend[5]}, 32'd0);
        irq_in[5] = 1'b0;
        repeat (4) tick();

        // Table: vector folding, latency, single pulse, grant clear.
        for (int t = 0; t < 8; t++) begin
            vw = tbl[t].width;
            irq_in[tbl[t].src] = 1'b1;
            wait_req(30, cyc);
            check($sformatf("tbl%0d_lat", t), cyc, 6);
            check($sformatf("tbl%0d_vec", t), {27'd0, vec}, {27'd0, tbl[t].exp_vec});
            grant_now();
            check($sformatf("tbl%0d_pulse", t), {31'd0, req}, 32'd0);
            check($sformatf("tbl%0d_clr", t), {31'd0, pend[tbl[t].src]}, 32'd0);
            irq_in[tbl[t].src] = 1'b0;
            repeat (4) tick();
        end
        vw = 3'd3;

        // Simultaneous edges on 1, 3, 6 served in order, 5 clocks apart.
        irq_in = 8'b0100_1010;
        wait_req(30, cyc);
        check("rr_first_vec", {27'd0, vec}, 32'd1);
        grant_now();
        wait_req(30, cyc);
        check("rr_second_vec", {27'd0, vec}, 32'd3);
        check("rr_spacing", cyc, 4);
        grant_now();
        wait_req(30, cyc);
        check("rr_third_vec", {27'd0, vec}, 32'd6);
        grant_now();
        check("rr_pend_all_clr", {24'd0, pend}, 32'd0);
        irq_in = '0;
        repeat (4) tick();
        irq_in[1] = 1'b1;
        wait_req(30, cyc);
        check("rr_wrap_vec", {27'd0, vec}, 32'd1);
        grant_now();
        irq_in[1] = 1'b0;
        repeat (4) tick();

        // Fail keeps pending and retries; no answer retries after timeout.
        irq_in[2] = 1'b1;
        wait_req(30, cyc);
        fail = 1'b1;
        tick();
        fail = 1'b0;
        check("fail_pend_kept", {31'd0, pend[2]}, 32'd1);
        wait_req(30, cyc);
        check("fail_retry_gap", cyc, 4);
        check("fail_retry_vec", {27'd0, vec}, 32'd2);
        grant_now();
        check("fail_grant_clr", {31'd0, pend[2]}, 32'd0);
        irq_in[2] = 1'b0;
        repeat (4) tick();
        irq_in[7] = 1'b1;
        wait_req(30, cyc);
        check("tmo_first_vec", {27'd0, vec}, 32'd7);
        wait_req(TMO + 30, cyc);
        // WaitGrant gives up TMO clocks after the request, then End, Idle,
        // Select and Send add four more clocks before the retry pulse.
        check("tmo_retry_gap", cyc, TMO + 4);
        check("tmo_pend_kept", {31'd0, pend[7]}, 32'd1);
        grant_now();
        irq_in[7] = 1'b0;
        repeat (4) tick();

        // Masked source: latched, not dispatched, overrun, unmask, clear.
        irq_mask[4] = 1'b1;
        irq_in[4] = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (req) req_seen++;
        end
        check("mask_pend", {31'd0, pend[4]}, 32'd1);
        check("mask_no_req", req_seen, 0);
        grant_now();
        check("grant_idle_ignored", {31'd0, pend[4]}, 32'd1);
        irq_in[4] = 1'b0;
        repeat (3) tick();
        check("ovr_before", {31'd0, ovr[4]}, 32'd0);
        irq_in[4] = 1'b1;
        repeat (4) tick();
        check("ovr_set", {31'd0, ovr[4]}, 32'd1);
        irq_mask[4] = 1'b0;
        wait_req(30, cyc);
        check("unmask_vec", {27'd0, vec}, 32'd4);
        grant_now();
        check("unmask_clr", {31'd0, pend[4]}, 32'd0);
        check("ovr_sticky", {31'd0, ovr[4]}, 32'd1);
        irq_clr[4] = 1'b1;
        tick();
        irq_clr[4] = 1'b0;
        check("ovr_clr", {31'd0, ovr[4]}, 32'd0);
        irq_in[4] = 1'b0;
        repeat (4) tick();

        // Level source 0 held high: repeated requests, no overrun.
        irq_in[0] = 1'b1;
        wait_req(30, cyc);
        check("lvl_vec1", {27'd0, vec}, 32'd0);
        grant_now();
        check("lvl_pend_held", {31'd0, pend[0]}, 32'd1);
        wait_req(30, cyc);
        check("lvl_repeat_gap", cyc, 4);
        check("lvl_vec2", {27'd0, vec}, 32'd0);
        grant_now();
        wait_req(30, cyc);
        check("lvl_ovr", {31'd0, ovr[0]}, 32'd0);
        // Disable during WaitGrant.
        en = 1'b0;
        tick();
        check("dis_req", {31'd0, req}, 32'd0);
        check("dis_pend", {24'd0, pend}, 32'd0);
        irq_in[0] = 1'b0;
        req_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (req) req_seen++;
        end
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req) req_seen++;
        end
        check("dis_no_req", req_seen, 0);
        check("dis_pend_after", {24'd0, pend}, 32'd0);

        // Asynchronous reset mid-request.
        irq_in[3] = 1'b1;
        wait_req(30, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, req}, 32'd0);
        check("arst_vec", {27'd0, vec}, 32'd0);
        check("arst_pend", {24'd0, pend}, 32'd0);
        irq_in = '0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
